dsp_mac_sequencer: RTL
======================

// Module: dsp_mac_sequencer
// PURPOSE
//  Sequences the DSP48A1-style slice (DSP) as a streaming unsigned dot-product engine.
//  Accepts LEN operand pairs (a,b) over a valid/ready stream and drives the slice's A/B/OPMODE/CE/RST ports.
//  Clears the accumulator on the first product and accumulates P=P+M for the rest.
//  Captures the final P and presents it on a valid/ready result port.
//  Sits between the operand source and one DSP instance; it is the only driver of that slice's control ports.
// PARAMETERS
//  LEN_W    12  width of vector-length input; LEN <= 2^LEN_W-1 keeps sum of 36b products within 48b
//  DSP_LAT   3  edges from A/B port to P output (A1REG/B1REG=1, MREG=1, PREG=1)
//  OPM_DLY   1  cycles OPMODE trails the A/B issue so OPMODEREG aligns with the M register
// PORTS
//  CLK          in   1      single clock, rising edge
//  RST          in   1      synchronous, active-high; resets controller and drives slice resets
//  start        in   1      pulse in IDLE launches a vector; ignored in any other state
//  len          in   LEN_W  vector length, sampled on start
//  busy         out  1      high from the cycle after accepted start until res handshake
//  in_valid     in   1      operand pair valid
//  in_ready     out  1      high only in RUN while issued count < len
//  in_a         in   18     unsigned operand a
//  in_b         in   18     unsigned operand b
//  res_valid    out  1      result valid; held until res_ready
//  res_ready    in   1      result consumer ready
//  res_data     out  48     dot-product result, stable while res_valid
//  dsp_A,dsp_B  out  18     to slice A/B; zero on bubbles
//  dsp_OPMODE   out  8      to slice OPMODE (pre-adder off, carry 0, add)
//  dsp_CE       out  1      drives CEA/CEB/CEM/CEP/CEOPMODE; constant 1 outside reset
//  dsp_RST      out  1      drives RSTA/RSTB/RSTM/RSTP/RSTOPMODE; equals RST combinationally
//  dsp_P        in   48     slice P output
// BEHAVIOUR
//  Reset: state=IDLE; busy, in_ready, res_valid = 0; res_data, dsp_A, dsp_B = 0; dsp_OPMODE = OPM_ZERO.
//  Reset takes effect on any cycle, including mid-RUN/DRAIN. In-flight products are discarded.
//  States:
//   IDLE->RUN on start with len!=0; IDLE->OUT on start with len==0, res_data=0, res_valid one cycle later.
//   RUN: in_valid&in_ready issues a beat (dsp_A/B = in_a/in_b); otherwise a bubble (dsp_A/B = 0).
//        RUN->DRAIN on the edge that issues beat len-1.
//   DRAIN: count DSP_LAT cycles, then capture dsp_P into res_data and go to OUT.
//   OUT: res_valid=1; OUT->IDLE on res_ready, res_valid cleared the same edge.
//  OPMODE codes, applied OPM_DLY cycles after the matching A/B cycle via a delay line:
//   OPM_FIRST 8'h01  first beat: X=M, Z=0
//   OPM_ACC   8'h09  later beats: X=M, Z=P
//   OPM_HOLD  8'h08  bubble after the first beat: X=0, Z=P
//   OPM_ZERO  8'h00  bubble before the first beat, IDLE, and after reset
//  Latency: res_valid rises DSP_LAT+1 cycles after the handshake edge of the last beat, with no backpressure.
//  Bubbles never corrupt the sum. Arbitrary in_valid gaps give the same result as back-to-back beats.
//  Arithmetic: products are unsigned 36b; the 48b accumulation wraps mod 2^48 with no saturation.
//  start during RUN/DRAIN/OUT is ignored. len changes after start are ignored.
//  in_ready drops combinationally once len beats are issued. No extra beat is ever accepted.
// STRUCTURE
//  Package dsp_ctrl_pkg: OPM_* constants, state encoding (IDLE/RUN/DRAIN/OUT), DSP_LAT default.
//  Sub-module dsp_opmode_pipe: OPM_DLY-deep OPMODE delay line with synchronous reset to OPM_ZERO.
//  Top holds the FSM, the issued-beat counter (LEN_W bits), the drain counter and the result register.
// TESTING (bench instantiates a real DSP, OPMODEREG=1)
//  len=4, a={1,2,3,4}, b={5,6,7,8}, back-to-back -> res_data=70, res_valid 4 cycles after the last beat.
//  Same vector with in_valid low for 3 cycles between beats 1 and 2, and before beat 0 -> res_data=70.
//  len=1, a=18'h3FFFF, b=18'h3FFFF -> res_data=48'h0000F_FFF8_0001; then len=0 -> res_data=0.
//  res_ready held low 5 cycles -> res_valid and res_data stable; a start pulse meanwhile is ignored.
//  RST pulsed mid-RUN after 2 of 4 beats -> IDLE next cycle; then a new len=2 {3,3}x{3,3} -> 18.
//  Random len in 1..64 with random a/b/gaps, 200 vectors -> each result matches a 48b reference sum.

Source files
------------

// File: rtl/dsp_ctrl_pkg.sv
// Shared constants for the DSP48A1 MAC sequencer: OPMODE codes, default
// pipeline depths and the controller state encoding.
package dsp_ctrl_pkg;

    localparam int LEN_W_DEF   = 12;
    localparam int DSP_LAT_DEF = 3;
    localparam int OPM_DLY_DEF = 1;

    // X mux in bits [1:0], Z mux in bits [3:2]; pre-adder, carry and subtract stay off.
    localparam logic [7:0] OPM_ZERO  = 8'h00;
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_HOLD  = 8'h08;
    localparam logic [7:0] OPM_ACC   = 8'h09;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
    } seq_state_e;

endpackage

// File: rtl/dsp_opmode_pipe.sv
// Delay line that lines the OPMODE for a beat up with that beat's product,
// matching the slice's A/B register stage ahead of the M register.
module dsp_opmode_pipe
    import dsp_ctrl_pkg::*;
#(
    parameter int DEPTH = OPM_DLY_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] opmode_i,
    output logic [7:0] opmode_o
);

    logic [7:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= OPM_ZERO;
            end
        end else begin
            stage_q[0] <= opmode_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign opmode_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streams LEN operand pairs into one DSP48A1 slice as an unsigned dot product
// and returns the accumulated P over a valid/ready result port.
module dsp_mac_sequencer
    import dsp_ctrl_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int DSP_LAT = DSP_LAT_DEF,
    parameter int OPM_DLY = OPM_DLY_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic [17:0]      dsp_A,
    output logic [17:0]      dsp_B,
    output logic [7:0]       dsp_OPMODE,
    output logic             dsp_CE,
    output logic             dsp_RST,
    input  logic [47:0]      dsp_P
);

    localparam int DRAIN_W = $clog2(DSP_LAT + 1);

    seq_state_e         state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [47:0]        res_q, res_d;
    logic [17:0]        a_q, a_d;
    logic [17:0]        b_q, b_d;
    logic [7:0]         opm_q, opm_d;
    logic               fire;

    assign in_ready  = (state_q == RUN) && (cnt_q < len_q);
    assign fire      = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == OUT);
    assign res_data  = res_q;
    assign dsp_A     = a_q;
    assign dsp_B     = b_q;
    assign dsp_RST   = RST;
    assign dsp_CE    = !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            opm_q   <= OPM_ZERO;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opm_q   <= opm_d;
        end
    end

    // Bubbles issue zero operands; HOLD once the accumulator has been seeded so P is kept.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        res_d   = res_q;
        a_d     = '0;
        b_d     = '0;
        opm_d   = OPM_ZERO;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d = len;
                    cnt_d = '0;
                    if (len == '0) begin
                        res_d   = '0;
                        state_d = OUT;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (fire) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    opm_d = (cnt_q == '0) ? OPM_FIRST : OPM_ACC;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end
                end else begin
                    opm_d = (cnt_q == '0) ? OPM_ZERO : OPM_HOLD;
                end
            end
            DRAIN: begin
                opm_d = OPM_HOLD;
                if (drain_q == DRAIN_W'(DSP_LAT)) begin
                    res_d   = dsp_P;
                    state_d = OUT;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            OUT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    dsp_opmode_pipe #(
        .DEPTH(OPM_DLY)
    ) u_opmode_pipe (
        .clk_i   (CLK),
        .rst_i   (RST),
        .opmode_i(opm_q),
        .opmode_o(dsp_OPMODE)
    );

endmodule
